reaction_timer: RTL and testbench

- Player-side responder for the F1 start-light sequence.
- Watches the 8-bit light bar driven by the start-light FSM and the player's button.
- Measures the time between lights-out and the button press in tick units (1 ms with the clktick divider), flags jump starts and timeouts, and keeps a best-time register.
- Sits beside the start-light top and consumes its data_out; drives the result display.

---
 rtl/reaction_timer.sv | 151 +++++++++++++++
 tb/tb_reaction_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - F1 start-light reaction timer with jump-start, timeout and best-time tracking
module reaction_timer #(
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [7:0]       lights,
    input  logic             button,
    output logic [WIDTH-1:0] reaction,
    output logic             result_valid,
    output logic             jump_start,
    output logic             timeout,
    output logic [WIDTH-1:0] best,
    output logic             timing
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_M1  = WIDTH'(MAX_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        TIMING = 3'd2,
        DONE   = 3'd3,
        FOUL   = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] counter, counter_d;
    logic             full, full_d;
    logic             button_q;
    logic             press;
    logic [WIDTH-1:0] reaction_d;
    logic             result_valid_d;
    logic             jump_start_d;
    logic             timeout_d;
    logic [WIDTH-1:0] best_d;

    // Only a rising edge of the button is a press; history resets high so a held button is ignored
    assign press  = button & ~button_q;
    assign timing = (state == TIMING);

    // Button history register, updated every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            button_q <= 1'b1;
        end else begin
            button_q <= button;
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            full         <= 1'b0;
            reaction     <= '0;
            result_valid <= 1'b0;
            jump_start   <= 1'b0;
            timeout      <= 1'b0;
            best         <= MAX_VAL;
        end else begin
            state        <= state_d;
            counter      <= counter_d;
            full         <= full_d;
            reaction     <= reaction_d;
            result_valid <= result_valid_d;
            jump_start   <= jump_start_d;
            timeout      <= timeout_d;
            best         <= best_d;
        end
    end

    // Next-state and next-value logic; a press always outranks lights-out and the final tick
    always_comb begin
        state_d        = state;
        counter_d      = counter;
        full_d         = full;
        reaction_d     = reaction;
        result_valid_d = 1'b0;
        jump_start_d   = jump_start;
        timeout_d      = timeout;
        best_d         = best;

        case (state)
            IDLE: begin
                if (lights != 8'h00) begin
                    state_d   = ARMED;
                    full_d    = 1'b0;
                    counter_d = '0;
                end
            end

            ARMED: begin
                if (lights == 8'hFF) begin
                    full_d = 1'b1;
                end
                if (press) begin
                    state_d      = FOUL;
                    jump_start_d = 1'b1;
                end else if (lights == 8'h00) begin
                    if (full) begin
                        state_d   = TIMING;
                        counter_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            TIMING: begin
                if (press) begin
                    reaction_d     = counter;
                    result_valid_d = 1'b1;
                    if (counter < best) begin
                        best_d = counter;
                    end
                    state_d = DONE;
                end else if (tick) begin
                    if (counter >= MAX_M1) begin
                        counter_d      = MAX_VAL;
                        reaction_d     = MAX_VAL;
                        result_valid_d = 1'b1;
                        timeout_d      = 1'b1;
                        state_d        = DONE;
                    end else begin
                        counter_d = counter + WIDTH'(1);
                    end
                end
            end

            DONE, FOUL: begin
                if (lights != 8'h00) begin
                    state_d      = ARMED;
                    jump_start_d = 1'b0;
                    timeout_d    = 1'b0;
                    full_d       = 1'b0;
                    counter_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - directed self-checking bench for reaction_timer
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [7:0]  lights;
    logic        button;

    logic [15:0] reaction, best;
    logic        result_valid, jump_start, timeout, timing;
    logic [15:0] t_reaction, t_best;
    logic        t_result_valid, t_jump_start, t_timeout, t_timing;

    int vectors = 0;
    int miscompares = 0;

    reaction_timer #(.WIDTH(16), .MAX_COUNT(9999)) dut (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights), .button(button),
        .reaction(reaction), .result_valid(result_valid), .jump_start(jump_start),
        .timeout(timeout), .best(best), .timing(timing)
    );

    reaction_timer #(.WIDTH(16), .MAX_COUNT(20)) dut_to (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights), .button(button),
        .reaction(t_reaction), .result_valid(t_result_valid), .jump_start(t_jump_start),
        .timeout(t_timeout), .best(t_best), .timing(t_timing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic ramp;
        lights = 8'h01;
        cyc();
        repeat (7) begin
            lights = {lights[6:0], 1'b1};
            cyc();
        end
    endtask

    task automatic lights_out;
        lights = 8'h00;
        cyc();
    endtask

    task automatic press_release;
        button = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; button = 1'b1; lights = 8'h00;
        cyc(); cyc();
        chk("rst_reaction", reaction, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_jump", jump_start, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_best", best, 9999);
        chk("rst_timing", timing, 0);
        chk("rst_best_to", t_best, 20);

        // Button held through reset and lights-out: no press, no foul
        rst = 1'b0;
        cyc();
        ramp();
        lights_out();
        chk("held_timing", timing, 1);
        chk("held_jump", jump_start, 0);
        button = 1'b0;
        cyc();

        // Run 1: 250 ticks
        do_ticks(250);
        press_release();
        chk("r1_valid", result_valid, 1);
        chk("r1_reaction", reaction, 250);
        chk("r1_best", best, 250);
        chk("r1_timing", timing, 0);
        button = 1'b0;
        cyc();
        chk("r1_valid_pulse", result_valid, 0);
        chk("r1_hold", reaction, 250);

        // Run 2: 400 ticks, best unchanged
        ramp(); lights_out();
        do_ticks(400);
        press_release();
        chk("r2_reaction", reaction, 400);
        chk("r2_best", best, 250);
        button = 1'b0; cyc();

        // Run 3: 120 ticks, new best
        ramp(); lights_out();
        do_ticks(120);
        press_release();
        chk("r3_reaction", reaction, 120);
        chk("r3_best", best, 120);
        button = 1'b0; cyc();

        // Press coinciding with tick at counter 37: tick ignored
        ramp(); lights_out();
        do_ticks(37);
        tick = 1'b1; button = 1'b1;
        cyc();
        tick = 1'b0;
        chk("co_valid", result_valid, 1);
        chk("co_reaction", reaction, 37);
        chk("co_best", best, 37);
        button = 1'b0; cyc();

        // Jump start at lights 1F
        lights = 8'h01; cyc();
        lights = 8'h03; cyc();
        lights = 8'h07; cyc();
        lights = 8'h0F; cyc();
        lights = 8'h1F; button = 1'b1;
        cyc();
        chk("js_jump", jump_start, 1);
        chk("js_valid", result_valid, 0);
        chk("js_reaction", reaction, 37);
        button = 1'b0; lights = 8'h00;
        cyc();
        chk("js_hold", jump_start, 1);
        chk("js_timing", timing, 0);
        lights = 8'h01;
        cyc();
        chk("js_clear", jump_start, 0);

        // Press in the same cycle as lights-out is a foul
        repeat (7) begin
            lights = {lights[6:0], 1'b1};
            cyc();
        end
        lights = 8'h00; button = 1'b1;
        cyc();
        chk("lo_jump", jump_start, 1);
        chk("lo_timing", timing, 0);
        chk("lo_valid", result_valid, 0);
        button = 1'b0; cyc();

        // Abort before full bar: back to idle, nothing changes
        lights = 8'h01; cyc();
        lights = 8'h03; cyc();
        lights = 8'h00; cyc();
        chk("ab_timing", timing, 0);
        chk("ab_jump", jump_start, 0);
        chk("ab_reaction", reaction, 37);
        press_release();
        chk("ab_idle_press", result_valid, 0);
        button = 1'b0; cyc();

        // Short run gives both instances a valid best of 5
        ramp(); lights_out();
        do_ticks(5);
        press_release();
        chk("s_reaction", reaction, 5);
        chk("s_best", best, 5);
        chk("s_reaction_to", t_reaction, 5);
        chk("s_best_to", t_best, 5);
        chk("s_timeout_to", t_timeout, 0);
        button = 1'b0; cyc();

        // Press with the final tick wins: normal result MAX_COUNT-1
        ramp(); lights_out();
        do_ticks(19);
        tick = 1'b1; button = 1'b1;
        cyc();
        tick = 1'b0;
        chk("m1_valid_to", t_result_valid, 1);
        chk("m1_reaction_to", t_reaction, 19);
        chk("m1_timeout_to", t_timeout, 0);
        chk("m1_best_to", t_best, 5);
        button = 1'b0; cyc();

        // Timeout after the 20th tick
        ramp(); lights_out();
        do_ticks(19);
        chk("to_pre_timeout", t_timeout, 0);
        chk("to_pre_timing", t_timing, 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("to_valid", t_result_valid, 1);
        chk("to_reaction", t_reaction, 20);
        chk("to_timeout", t_timeout, 1);
        chk("to_best", t_best, 5);
        chk("to_timing", t_timing, 0);
        chk("to_main_timing", timing, 1);
        cyc();
        chk("to_valid_pulse", t_result_valid, 0);
        chk("to_hold", t_timeout, 1);

        // Reset while the main instance is timing
        rst = 1'b1;
        cyc();
        chk("mr_reaction", reaction, 0);
        chk("mr_best", best, 9999);
        chk("mr_timing", timing, 0);
        chk("mr_valid", result_valid, 0);
        chk("mr_jump", jump_start, 0);
        chk("mr_timeout", timeout, 0);
        chk("mr_best_to", t_best, 20);
        chk("mr_timeout_to", t_timeout, 0);
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
